// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed word stream, writes it into the
// instruction memory from address 0, pads the rest with FILL_WORD and holds the core
// in reset until the image is complete.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing checksum word.
module prog_loader #(
    parameter int unsigned            DATA_BITS  = 8,
    parameter int unsigned            ADDR_BITS  = 8,
    parameter int unsigned            MEM_DEPTH  = 256,
    parameter logic [DATA_BITS-1:0]   FILL_WORD  = '0,
    parameter int unsigned            RESET_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic                 core_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StLoad,
        StFill,
        StCsum,
        StHold,
        StDone,
        StError
    } state_e;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e StAfterData = StCsum;
`else
    localparam state_e StAfterData = StHold;
`endif

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   len_q, len_d;
    logic [HoldW-1:0]       hold_q, hold_d;
    logic                   we_d;
    logic [ADDR_BITS-1:0]   addr_d;
    logic [DATA_BITS-1:0]   wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_BITS-1:0]   sum_q, sum_d;
`endif

    logic accept;
    logic last_load;
    logic last_fill;

    assign accept    = in_valid & in_ready;
    // Compared in 32 bits so the address counter never has to step past MEM_DEPTH-1.
    assign last_load = (32'(cnt_q) == (32'(len_q) - 32'd1));
    assign last_fill = (32'(cnt_q) == (MEM_DEPTH - 32'd1));

    // State-decoded status outputs.
    always_comb begin
        in_ready   = (state_q == StLen) || (state_q == StLoad) || (state_q == StCsum);
        busy       = (state_q == StLen) || (state_q == StLoad) || (state_q == StFill) ||
                     (state_q == StCsum) || (state_q == StHold);
        done       = (state_q == StDone);
        err        = (state_q == StError);
        core_reset = (state_q != StDone);
    end

    // Next-state, counters and the registered memory write port.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        hold_d  = '0;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) state_d = StLen;
            end
            StLen: begin
                if (accept) begin
                    len_d = in_data;
                    cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d = '0;
`endif
                    if (32'(in_data) > MEM_DEPTH) begin
                        state_d = StError;
                    end else if (in_data == '0) begin
                        state_d = StFill;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = in_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                    if (last_load) begin
                        if (32'(len_q) < MEM_DEPTH) begin
                            cnt_d   = cnt_q + ADDR_BITS'(1);
                            state_d = StFill;
                        end else begin
                            state_d = StAfterData;
                        end
                    end else begin
                        cnt_d = cnt_q + ADDR_BITS'(1);
                    end
                end
            end
            StFill: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = FILL_WORD;
                if (last_fill) begin
                    state_d = StAfterData;
                end else begin
                    cnt_d = cnt_q + ADDR_BITS'(1);
                end
            end
            StCsum: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = (in_data == sum_q) ? StHold : StError;
                end
`else
                state_d = StIdle;
`endif
            end
            StHold: begin
                if (hold_q == HoldW'(RESET_HOLD - 1)) begin
                    state_d = StDone;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StDone, StError: begin
                if (start) state_d = StLen;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and write-port registers; synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            hold_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            hold_q    <= hold_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

endmodule
